// File: rtl/uart_mem_loader.sv
// UART boot loader: parses SYNC/COUNT/data/CHK frames and writes big-endian words to memory.
// Optional trailing checksum byte is enabled with `define MEM_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  MemWrite_en,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam int         CW    = ADDR_WIDTH + 1;
  localparam int         TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
`ifdef MEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [23:0]     shift;
  logic [1:0]      byte_idx;
  logic [CW-1:0]   count;
  logic [CW-1:0]   word_cnt;
  logic [TW-1:0]   tmo;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]      chk_acc;
`endif

  logic sync_seen;
  logic last_word;
  logic timed_state;

  assign sync_seen   = rx_valid && (rx_data == SYNC_BYTE);
  assign last_word   = (word_cnt == count - CW'(1));
`ifdef MEM_LOADER_CHECKSUM_EN
  assign timed_state = (state == S_COUNT) || (state == S_DATA) || (state == S_CHK);
`else
  assign timed_state = (state == S_COUNT) || (state == S_DATA);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shift       <= '0;
      byte_idx    <= '0;
      count       <= '0;
      word_cnt    <= '0;
      tmo         <= '0;
      Address     <= '0;
      WriteData   <= '0;
      MemWrite_en <= 1'b0;
      cpu_hold    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      chk_acc     <= '0;
`endif
    end else begin
      MemWrite_en <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // DONE and ERR restart straight into COUNT on a new sync byte
          if (sync_seen) begin
            state    <= S_COUNT;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            tmo      <= '0;
          end
        end

        S_COUNT: begin
          if (rx_valid) begin
            if ({1'b0, rx_data} > DEPTH_9) begin
              state <= S_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state    <= S_DATA;
              count    <= (rx_data == 8'h00) ? CW'(DEPTH) : CW'(rx_data);
              Address  <= '0;
              byte_idx <= '0;
              word_cnt <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
              chk_acc  <= '0;
`endif
            end
          end
        end

        S_DATA: begin
          // Bookkeeping for the word strobed last cycle; Address holds on the final word
          if (MemWrite_en) begin
            word_cnt <= word_cnt + CW'(1);
            if (last_word) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              Address <= Address + ADDR_WIDTH'(1);
            end
          end
          if (rx_valid) begin
            shift    <= {shift[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
              WriteData   <= DATA_WIDTH'({shift, rx_data});
              MemWrite_en <= 1'b1;
            end
          end
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == chk_acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Inter-byte watchdog; never fires while a word strobe is being retired
      if (timed_state) begin
        if (rx_valid) begin
          tmo <= '0;
        end else if (!MemWrite_en) begin
          if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= S_ERR;
            busy  <= 1'b0;
            error <= 1'b1;
            tmo   <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: expected writes are queued by the stimulus
// and popped by an independent monitor on every MemWrite_en pulse.
module tb_uart_mem_loader;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 200;

`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic          MemWrite_en;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;

  uart_mem_loader #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .Address    (Address),
    .WriteData  (WriteData),
    .MemWrite_en(MemWrite_en),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Monitor: every strobe must match the oldest queued write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (MemWrite_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", Address, WriteData);
        end else begin
          e = exp_q.pop_front();
          if (e.addr !== Address || e.data !== WriteData) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     Address, WriteData, e.addr, e.data);
          end else begin
            $display("write addr=%0d data=%h ok", Address, WriteData);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, pending writes=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int addr, input logic [31:0] w);
    exp_q.push_back('{addr: AW'(addr), data: w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(Address), 32'h0);
    chk({tag, "_wdata"}, WriteData, 32'h0);
    chk({tag, "_we"}, 32'(MemWrite_en), 32'h0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
  endtask

  // Frame A: two words; XOR of its data bytes FA^20^3F^FF^E0 = FA
  task automatic frame_a(input logic [7:0] chk_byte);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_word(0, 32'h0000_00FA);
    send_word(1, 32'h203F_FFE0);
    send_byte(chk_byte);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");

    send_byte(8'h00);
    send_byte(8'h3C);
    chk("idle_noise_hold", 32'(cpu_hold), 32'h0);
    chk("idle_noise_busy", 32'(busy), 32'h0);

    send_byte(8'hA5);
    chk("sync_hold", 32'(cpu_hold), 32'h1);
    chk("sync_busy", 32'(busy), 32'h1);
    send_byte(8'h02);
    send_word(0, 32'h0000_00FA);
    send_word(1, 32'h203F_FFE0);
    send_byte(8'hFA);
    check_status("frame_a", 1'b1, 1'b0, 1'b0);
    chk("frame_a_last_addr", 32'(Address), 32'h1);

    // Full-depth load: data byte value = index, XOR of 0..63 is 00
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 16; i++) begin
      send_word(i, {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
    end
    send_byte(8'h00);
    check_status("full", 1'b1, 1'b0, 1'b0);
    chk("full_last_addr", 32'(Address), 32'hF);

    frame_a(8'h00);
    if (CHK_EN) check_status("bad_chk", 1'b0, 1'b1, 1'b1);
    else        check_status("bad_chk", 1'b1, 1'b0, 1'b0);
    frame_a(8'hFA);
    check_status("recover", 1'b1, 1'b0, 1'b0);

    send_byte(8'hA5);
    send_byte(8'h11);
    check_status("count_big", 1'b0, 1'b1, 1'b1);

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (TMO + 20) @(posedge clk);
    #1 check_status("timeout", 1'b0, 1'b1, 1'b1);

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_hold", 32'(cpu_hold), 32'h1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // DE^AD^BE^EF = 22
    send_byte(8'hA5);
    send_byte(8'h01);
    send_word(0, 32'hDEAD_BEEF);
    send_byte(8'h22);
    check_status("post_reset", 1'b1, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
